// File: rtl/vx_mem_perf_monitor.sv
// Per-channel memory performance monitor: read/write lane counts, outstanding reads,
// accumulated read latency, sticky overflow/underflow flags and an atomic snapshot port.
module vx_mem_perf_monitor #(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned CTR_WIDTH    = 44,
  parameter int unsigned PEND_WIDTH   = 16,
  parameter bit          SATURATE     = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           req_valid,
  input  logic [NUM_CHANNELS-1:0]           req_ready,
  input  logic [NUM_CHANNELS-1:0]           req_rw,
  input  logic [NUM_CHANNELS*NUM_LANES-1:0] req_mask,
  input  logic [NUM_CHANNELS-1:0]           rsp_valid,
  input  logic [NUM_CHANNELS-1:0]           rsp_ready,
  input  logic [NUM_CHANNELS*NUM_LANES-1:0] rsp_mask,
  input  logic                              clear,
  input  logic                              freeze,
  input  logic                              snap_req,
  output logic [NUM_CHANNELS*CTR_WIDTH-1:0]  reads,
  output logic [NUM_CHANNELS*CTR_WIDTH-1:0]  writes,
  output logic [NUM_CHANNELS*CTR_WIDTH-1:0]  latency,
  output logic [NUM_CHANNELS*PEND_WIDTH-1:0] pending,
  output logic [NUM_CHANNELS*CTR_WIDTH-1:0]  snap_reads,
  output logic [NUM_CHANNELS*CTR_WIDTH-1:0]  snap_writes,
  output logic [NUM_CHANNELS*CTR_WIDTH-1:0]  snap_latency,
  output logic                              snap_valid,
  output logic [NUM_CHANNELS-1:0]           overflow,
  output logic [NUM_CHANNELS-1:0]           underflow
);

  localparam int unsigned NC = NUM_CHANNELS;
  localparam int unsigned NL = NUM_LANES;
  localparam int unsigned LW = $clog2(NUM_LANES + 1);
  localparam int unsigned PW = PEND_WIDTH + LW + 1;
  localparam int unsigned SW = ((PEND_WIDTH > CTR_WIDTH) ? PEND_WIDTH : CTR_WIDTH) + 1;

  function automatic logic [LW-1:0] popcnt(input logic [NL-1:0] m);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(NL); i++) n = n + LW'(m[i]);
    return n;
  endfunction

  // Returns {carry, next value}; saturating mode pins the value at all-ones on carry.
  function automatic logic [CTR_WIDTH:0] ctr_add(input logic [CTR_WIDTH-1:0] base,
                                                 input logic [SW-1:0] inc);
    logic [SW-1:0] sum;
    logic          carry;
    sum   = SW'(base) + inc;
    carry = |sum[SW-1:CTR_WIDTH];
    if (carry && SATURATE) return {1'b1, {CTR_WIDTH{1'b1}}};
    return {carry, sum[CTR_WIDTH-1:0]};
  endfunction

  logic [LW-1:0]           rd_d   [NC];
  logic [LW-1:0]           wr_d   [NC];
  logic [LW-1:0]           rsp_d  [NC];
  logic [LW-1:0]           rd_q   [NC];
  logic [LW-1:0]           wr_q   [NC];
  logic [LW-1:0]           rsp_q  [NC];
  logic [CTR_WIDTH-1:0]    reads_q[NC];
  logic [CTR_WIDTH-1:0]    writes_q[NC];
  logic [CTR_WIDTH-1:0]    lat_q  [NC];
  logic [PEND_WIDTH-1:0]   pend_q [NC];
  logic [PEND_WIDTH-1:0]   pend_n [NC];
  logic signed [PW-1:0]    p_sum  [NC];
  logic [CTR_WIDTH:0]      rd_add [NC];
  logic [CTR_WIDTH:0]      wr_add [NC];
  logic [CTR_WIDTH:0]      lat_add[NC];
  logic [CTR_WIDTH-1:0]    snap_rd_q[NC];
  logic [CTR_WIDTH-1:0]    snap_wr_q[NC];
  logic [CTR_WIDTH-1:0]    snap_lat_q[NC];
  logic [NC-1:0]           pend_uf;
  logic [NC-1:0]           pend_of;
  logic [NC-1:0]           ovf_q;
  logic [NC-1:0]           udf_q;

  // Fired lane counts and next counter values for every channel.
  always_comb begin
    pend_uf = '0;
    pend_of = '0;
    for (int c = 0; c < int'(NC); c++) begin
      rd_d[c]  = (req_valid[c] & req_ready[c] & ~req_rw[c]) ? popcnt(req_mask[c*NL +: NL]) : '0;
      wr_d[c]  = (req_valid[c] & req_ready[c] &  req_rw[c]) ? popcnt(req_mask[c*NL +: NL]) : '0;
      rsp_d[c] = (rsp_valid[c] & rsp_ready[c]) ? popcnt(rsp_mask[c*NL +: NL]) : '0;

      p_sum[c]   = $signed(PW'(pend_q[c])) + $signed(PW'(rd_q[c])) - $signed(PW'(rsp_q[c]));
      pend_uf[c] = p_sum[c][PW-1];
      pend_of[c] = ~p_sum[c][PW-1] & (|p_sum[c][PW-2:PEND_WIDTH]);
      pend_n[c]  = pend_uf[c] ? '0 : (pend_of[c] ? '1 : p_sum[c][PEND_WIDTH-1:0]);

      rd_add[c]  = ctr_add(reads_q[c],  SW'(rd_q[c]));
      wr_add[c]  = ctr_add(writes_q[c], SW'(wr_q[c]));
      lat_add[c] = ctr_add(lat_q[c],    SW'(pend_q[c]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_valid <= 1'b0;
      ovf_q      <= '0;
      udf_q      <= '0;
      for (int c = 0; c < int'(NC); c++) begin
        rd_q[c]       <= '0;
        wr_q[c]       <= '0;
        rsp_q[c]      <= '0;
        pend_q[c]     <= '0;
        reads_q[c]    <= '0;
        writes_q[c]   <= '0;
        lat_q[c]      <= '0;
        snap_rd_q[c]  <= '0;
        snap_wr_q[c]  <= '0;
        snap_lat_q[c] <= '0;
      end
    end else begin
      snap_valid <= snap_req;
      for (int c = 0; c < int'(NC); c++) begin
        rd_q[c]   <= rd_d[c];
        wr_q[c]   <= wr_d[c];
        rsp_q[c]  <= rsp_d[c];
        pend_q[c] <= pend_n[c];
        // Snapshot takes pre-update values, so snap with clear is an atomic read-and-clear.
        if (snap_req) begin
          snap_rd_q[c]  <= reads_q[c];
          snap_wr_q[c]  <= writes_q[c];
          snap_lat_q[c] <= lat_q[c];
        end
        if (clear) begin
          reads_q[c]  <= '0;
          writes_q[c] <= '0;
          lat_q[c]    <= '0;
          ovf_q[c]    <= 1'b0;
          udf_q[c]    <= 1'b0;
        end else begin
          udf_q[c] <= udf_q[c] | pend_uf[c];
          ovf_q[c] <= ovf_q[c] | pend_of[c] |
                      (~freeze & (rd_add[c][CTR_WIDTH] | wr_add[c][CTR_WIDTH] | lat_add[c][CTR_WIDTH]));
          if (!freeze) begin
            reads_q[c]  <= rd_add[c][CTR_WIDTH-1:0];
            writes_q[c] <= wr_add[c][CTR_WIDTH-1:0];
            lat_q[c]    <= lat_add[c][CTR_WIDTH-1:0];
          end
        end
      end
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;

  for (genvar g = 0; g < int'(NC); g++) begin : g_out
    assign reads       [g*CTR_WIDTH  +: CTR_WIDTH]  = reads_q[g];
    assign writes      [g*CTR_WIDTH  +: CTR_WIDTH]  = writes_q[g];
    assign latency     [g*CTR_WIDTH  +: CTR_WIDTH]  = lat_q[g];
    assign pending     [g*PEND_WIDTH +: PEND_WIDTH] = pend_q[g];
    assign snap_reads  [g*CTR_WIDTH  +: CTR_WIDTH]  = snap_rd_q[g];
    assign snap_writes [g*CTR_WIDTH  +: CTR_WIDTH]  = snap_wr_q[g];
    assign snap_latency[g*CTR_WIDTH  +: CTR_WIDTH]  = snap_lat_q[g];
  end

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// Bench for vx_mem_perf_monitor: one wide saturating instance and two 8-bit instances
// (saturating, wrapping) share stimulus and are checked against a lane-count model.
module tb_vx_mem_perf_monitor;

  localparam int NC  = 2;
  localparam int NL  = 4;
  localparam int PWD = 16;
  localparam int CWB = 44;
  localparam int CWS = 8;
  localparam int FW  = NC * CWB;

  logic clk;
  logic reset;
  logic [NC-1:0]    req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
  logic [NC*NL-1:0] req_mask, rsp_mask;
  logic clear, freeze, snap_req;

  logic [NC*CWB-1:0] rd0, wr0, lt0, srd0, swr0, slt0;
  logic [NC*CWS-1:0] rd1, wr1, lt1, srd1, swr1, slt1;
  logic [NC*CWS-1:0] rd2, wr2, lt2, srd2, swr2, slt2;
  logic [NC*PWD-1:0] pd0, pd1, pd2;
  logic              sv0, sv1, sv2;
  logic [NC-1:0]     of0, of1, of2, uf0, uf1, uf2;

  vx_mem_perf_monitor #(.NUM_CHANNELS(NC), .NUM_LANES(NL), .CTR_WIDTH(CWB), .PEND_WIDTH(PWD), .SATURATE(1'b1)) u_big (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_mask(req_mask), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
    .clear(clear), .freeze(freeze), .snap_req(snap_req), .reads(rd0), .writes(wr0), .latency(lt0),
    .pending(pd0), .snap_reads(srd0), .snap_writes(swr0), .snap_latency(slt0), .snap_valid(sv0),
    .overflow(of0), .underflow(uf0));

  vx_mem_perf_monitor #(.NUM_CHANNELS(NC), .NUM_LANES(NL), .CTR_WIDTH(CWS), .PEND_WIDTH(PWD), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_mask(req_mask), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
    .clear(clear), .freeze(freeze), .snap_req(snap_req), .reads(rd1), .writes(wr1), .latency(lt1),
    .pending(pd1), .snap_reads(srd1), .snap_writes(swr1), .snap_latency(slt1), .snap_valid(sv1),
    .overflow(of1), .underflow(uf1));

  vx_mem_perf_monitor #(.NUM_CHANNELS(NC), .NUM_LANES(NL), .CTR_WIDTH(CWS), .PEND_WIDTH(PWD), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_mask(req_mask), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
    .clear(clear), .freeze(freeze), .snap_req(snap_req), .reads(rd2), .writes(wr2), .latency(lt2),
    .pending(pd2), .snap_reads(srd2), .snap_writes(swr2), .snap_latency(slt2), .snap_valid(sv2),
    .overflow(of2), .underflow(uf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: true (unbounded) counter sums since the last clear.
  longint m_p[NC], s_rd[NC], s_wr[NC], s_lat[NC], es_rd[NC], es_wr[NC], es_lat[NC];
  bit     m_uf[NC], m_pof[NC], e_sv;
  int     q_rd[NC], q_wr[NC], q_rsp[NC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fld(input logic [FW-1:0] v, input int c, input int cw);
    logic [FW-1:0] s;
    s = v >> (c * cw);
    return 64'(s) & ((64'd1 << cw) - 64'd1);
  endfunction

  function automatic longint cexp(input longint s, input int cw, input bit sat);
    longint mx;
    mx = (longint'(1) << cw) - 1;
    if (s <= mx) return s;
    return sat ? mx : (s & mx);
  endfunction

  task automatic model_reset();
    e_sv = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_p[c] = 0; s_rd[c] = 0; s_wr[c] = 0; s_lat[c] = 0;
      es_rd[c] = 0; es_wr[c] = 0; es_lat[c] = 0;
      m_uf[c] = 1'b0; m_pof[c] = 1'b0;
      q_rd[c] = 0; q_wr[c] = 0; q_rsp[c] = 0;
    end
  endtask

  task automatic model_edge();
    longint old_p, np;
    e_sv = snap_req;
    for (int c = 0; c < NC; c++) begin
      if (snap_req) begin
        es_rd[c] = s_rd[c]; es_wr[c] = s_wr[c]; es_lat[c] = s_lat[c];
      end
      old_p = m_p[c];
      np    = old_p + q_rd[c] - q_rsp[c];
      if (clear) begin
        s_rd[c] = 0; s_wr[c] = 0; s_lat[c] = 0; m_uf[c] = 1'b0; m_pof[c] = 1'b0;
      end else begin
        if (np < 0) m_uf[c] = 1'b1;
        if (np > 65535) m_pof[c] = 1'b1;
        if (!freeze) begin
          s_rd[c] += q_rd[c]; s_wr[c] += q_wr[c]; s_lat[c] += old_p;
        end
      end
      m_p[c]   = (np < 0) ? 0 : ((np > 65535) ? 65535 : np);
      q_rd[c]  = (req_valid[c] && req_ready[c] && !req_rw[c]) ? $countones(req_mask[c*NL +: NL]) : 0;
      q_wr[c]  = (req_valid[c] && req_ready[c] &&  req_rw[c]) ? $countones(req_mask[c*NL +: NL]) : 0;
      q_rsp[c] = (rsp_valid[c] && rsp_ready[c]) ? $countones(rsp_mask[c*NL +: NL]) : 0;
    end
  endtask

  task automatic check_cfg(input string nm, input int cw, input bit sat,
                           input logic [FW-1:0] rd, input logic [FW-1:0] wr, input logic [FW-1:0] lt,
                           input logic [FW-1:0] srd, input logic [FW-1:0] swr, input logic [FW-1:0] slt,
                           input logic [FW-1:0] pd, input logic sv, input logic [NC-1:0] of,
                           input logic [NC-1:0] uf);
    longint mx;
    bit     eof;
    mx = (longint'(1) << cw) - 1;
    for (int c = 0; c < NC; c++) begin
      eof = m_pof[c] || (s_rd[c] > mx) || (s_wr[c] > mx) || (s_lat[c] > mx);
      chk($sformatf("%s.reads[%0d]", nm, c),     fld(rd, c, cw),  64'(cexp(s_rd[c], cw, sat)));
      chk($sformatf("%s.writes[%0d]", nm, c),    fld(wr, c, cw),  64'(cexp(s_wr[c], cw, sat)));
      chk($sformatf("%s.latency[%0d]", nm, c),   fld(lt, c, cw),  64'(cexp(s_lat[c], cw, sat)));
      chk($sformatf("%s.pending[%0d]", nm, c),   fld(pd, c, PWD), 64'(m_p[c]));
      chk($sformatf("%s.snap_reads[%0d]", nm, c),   fld(srd, c, cw), 64'(cexp(es_rd[c], cw, sat)));
      chk($sformatf("%s.snap_writes[%0d]", nm, c),  fld(swr, c, cw), 64'(cexp(es_wr[c], cw, sat)));
      chk($sformatf("%s.snap_latency[%0d]", nm, c), fld(slt, c, cw), 64'(cexp(es_lat[c], cw, sat)));
      chk($sformatf("%s.overflow[%0d]", nm, c),  64'(of[c]), 64'(eof));
      chk($sformatf("%s.underflow[%0d]", nm, c), 64'(uf[c]), 64'(m_uf[c]));
    end
    chk($sformatf("%s.snap_valid", nm), 64'(sv), 64'(e_sv));
  endtask

  task automatic check_all();
    check_cfg("big",  CWB, 1'b1, rd0, wr0, lt0, srd0, swr0, slt0, FW'(pd0), sv0, of0, uf0);
    check_cfg("sat",  CWS, 1'b1, FW'(rd1), FW'(wr1), FW'(lt1), FW'(srd1), FW'(swr1), FW'(slt1), FW'(pd1), sv1, of1, uf1);
    check_cfg("wrap", CWS, 1'b0, FW'(rd2), FW'(wr2), FW'(lt2), FW'(srd2), FW'(swr2), FW'(slt2), FW'(pd2), sv2, of2, uf2);
  endtask

  // Inputs change only at posedge+1, well away from the sampling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    req_valid = '0; req_ready = '0; req_rw = '0; req_mask = '0;
    rsp_valid = '0; rsp_ready = '0; rsp_mask = '0;
    clear = 1'b0; freeze = 1'b0; snap_req = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Single 3-lane read on ch0, answered 5 cycles later.
    do_clear();
    req_valid[0] = 1'b1; req_ready[0] = 1'b1; req_mask[3:0] = 4'b1011;
    tick();
    idle();
    tick();
    chk("dir_rd3_reads", fld(rd0, 0, CWB), 64'd3);
    chk("dir_rd3_pending", fld(FW'(pd0), 0, PWD), 64'd3);
    tick(); tick(); tick();
    rsp_valid[0] = 1'b1; rsp_ready[0] = 1'b1; rsp_mask[3:0] = 4'b1011;
    tick();
    idle();
    tick();
    chk("dir_lat15", fld(lt0, 0, CWB), 64'd15);
    chk("dir_pend0", fld(FW'(pd0), 0, PWD), 64'd0);
    tick();

    // Ch1 writes, ready dropped on three of ten cycles.
    do_clear();
    for (int i = 0; i < 10; i++) begin
      req_valid[1] = 1'b1; req_rw[1] = 1'b1; req_mask[7:4] = 4'hF;
      req_ready[1] = !(i == 2 || i == 5 || i == 8);
      tick();
    end
    idle();
    tick(); tick();
    chk("dir_wr28", fld(wr0, 1, CWB), 64'd28);
    chk("dir_ch0_untouched", fld(rd0, 0, CWB) | fld(wr0, 0, CWB), 64'd0);

    // 70 full-mask reads: 280 lanes overflow the 8-bit counters.
    do_clear();
    for (int i = 0; i < 70; i++) begin
      req_valid[0] = 1'b1; req_ready[0] = 1'b1; req_mask[3:0] = 4'hF;
      tick();
    end
    idle();
    tick(); tick();
    chk("dir_big_reads280", fld(rd0, 0, CWB), 64'd280);
    chk("dir_sat_reads255", fld(FW'(rd1), 0, CWS), 64'd255);
    chk("dir_sat_ovf", 64'(of1[0]), 64'd1);
    chk("dir_wrap_reads24", fld(FW'(rd2), 0, CWS), 64'd24);
    chk("dir_wrap_ovf", 64'(of2[0]), 64'd1);
    for (int i = 0; i < 70; i++) begin
      rsp_valid[0] = 1'b1; rsp_ready[0] = 1'b1; rsp_mask[3:0] = 4'hF;
      tick();
    end
    idle();
    tick(); tick();
    chk("dir_drained", fld(FW'(pd0), 0, PWD), 64'd0);

    // Response with nothing outstanding.
    do_clear();
    rsp_valid[1] = 1'b1; rsp_ready[1] = 1'b1; rsp_mask[7:4] = 4'b0001;
    tick();
    idle();
    tick(); tick();
    chk("dir_udf_set", 64'(uf0[1]), 64'd1);
    chk("dir_udf_pend0", fld(FW'(pd0), 1, PWD), 64'd0);
    do_clear();
    chk("dir_udf_cleared", 64'(uf0[1]), 64'd0);

    // Atomic snapshot and clear.
    do_clear();
    for (int i = 0; i < 3; i++) begin
      req_valid[0] = 1'b1; req_ready[0] = 1'b1; req_mask[3:0] = 4'hF;
      tick();
    end
    idle();
    tick(); tick();
    chk("dir_reads12", fld(rd0, 0, CWB), 64'd12);
    snap_req = 1'b1; clear = 1'b1;
    tick();
    idle();
    chk("dir_snap_valid", 64'(sv0), 64'd1);
    chk("dir_snap_reads12", fld(srd0, 0, CWB), 64'd12);
    chk("dir_reads_cleared", fld(rd0, 0, CWB), 64'd0);
    chk("dir_pend_kept", fld(FW'(pd0), 0, PWD), 64'd12);
    tick();
    chk("dir_snap_valid_pulse", 64'(sv0), 64'd0);
    for (int i = 0; i < 3; i++) begin
      rsp_valid[0] = 1'b1; rsp_ready[0] = 1'b1; rsp_mask[3:0] = 4'hF;
      tick();
    end
    idle();
    tick(); tick();

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++) begin
        req_valid[c] = 1'($urandom_range(0, 1));
        req_ready[c] = 1'($urandom_range(0, 3) != 0);
        req_rw[c]    = 1'($urandom_range(0, 1));
        req_mask[c*NL +: NL] = 4'($urandom_range(0, 15));
        rsp_valid[c] = 1'($urandom_range(0, 2) == 0);
        rsp_ready[c] = 1'($urandom_range(0, 3) != 0);
        rsp_mask[c*NL +: NL] = 4'($urandom_range(0, 15));
      end
      freeze   = 1'($urandom_range(0, 9) == 0);
      clear    = 1'($urandom_range(0, 59) == 0);
      snap_req = 1'($urandom_range(0, 7) == 0);
      tick();
      if (i == 200) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        tick(); tick();
        reset = 1'b0;
      end
    end
    idle();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
